// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter that shares one SHA-256 core among N_REQ requesters.
// One job in flight: grant, start pulse, wait for done or watchdog, return the tagged digest.
module sha256_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 127,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*512-1:0]   req_block,
    output logic [N_REQ-1:0]       req_ack,
    output logic                   core_tick,
    output logic                   core_final,
    output logic [511:0]           core_block,
    input  logic [255:0]           core_digest,
    input  logic                   core_done,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_digest,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [CNT_W-1:0]       jobs_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q,  state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q,     id_d;
    logic [511:0]      block_q,  block_d;
    logic [255:0]      digest_q, digest_d;
    logic              err_q,    err_d;
    logic [WD_W-1:0]   wdog_q,   wdog_d;
    logic [CNT_W-1:0]  jobs_q,   jobs_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [511:0]      grant_block;
    logic [N_REQ-1:0]  ack_raw;

    // Scan starting at rr_ptr and wrapping, so the most recently served requester goes last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
        grant_block = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_block = req_block[i*512 +: 512];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        block_d   = block_q;
        digest_d  = digest_q;
        err_d     = err_q;
        wdog_d    = wdog_q;
        jobs_d    = jobs_q;
        ack_raw   = '0;
        core_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    ack_raw[grant_idx] = 1'b1;
                    block_d  = grant_block;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_tick = 1'b1;
                wdog_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                // A done arriving on the final watchdog cycle still counts as success.
                if (core_done) begin
                    digest_d = core_digest;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (wdog_q == WD_LAST) begin
                    digest_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!err_q) begin
                        jobs_d = jobs_q + CNT_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            block_q  <= '0;
            digest_q <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            block_q  <= block_d;
            digest_q <= digest_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            jobs_q   <= jobs_d;
        end
    end

    // The ack is a Mealy output of IDLE, so it is forced low while reset is held.
    assign req_ack    = rst ? '0 : ack_raw;
    assign core_final = 1'b0;
    assign core_block = block_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_digest = digest_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != S_IDLE);
    assign jobs_done  = jobs_q;

endmodule
